// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array result path.
package systolic_pkg;

   localparam int unsigned DIM       = 3;
   localparam int unsigned N_ELEM    = DIM * DIM;
   localparam int          ACC_W_DEF = 20;
   localparam int          OUT_W_DEF = 16;

   // Position of the final element (C22) in the row-major drain order
   localparam logic [3:0]  LAST_IDX  = 4'd8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } drain_state_t;

   // Row of a row-major element index; out-of-range indices map to 0
   function automatic logic [1:0] idx_row(input logic [3:0] idx);
      logic [1:0] r;
      r = 2'd0;
      case (idx)
         4'd3, 4'd4, 4'd5: r = 2'd1;
         4'd6, 4'd7, 4'd8: r = 2'd2;
         default:          r = 2'd0;
      endcase
      return r;
   endfunction

   // Column of a row-major element index; out-of-range indices map to 0
   function automatic logic [1:0] idx_col(input logic [3:0] idx);
      logic [1:0] c;
      c = 2'd0;
      case (idx)
         4'd1, 4'd4, 4'd7: c = 2'd1;
         4'd2, 4'd5, 4'd8: c = 2'd2;
         default:          c = 2'd0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/systolic_result_drain_sat_narrow.sv
// Unsigned saturating narrower: clamps an ACC_W value to the OUT_W range.
module sat_narrow #(
   parameter int ACC_W = 20,
   parameter int OUT_W = 16
) (
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] narrow,
   output logic             sat
);

   generate
      if (ACC_W > OUT_W) begin : g_clip
         // Any set bit above the output width means the value cannot be represented
         always_comb sat = |acc[ACC_W-1:OUT_W];
      end else begin : g_pass
         // Equal widths: every value fits
         always_comb sat = 1'b0;
      end
   endgenerate

   // Select the clamp value or the low bits
   always_comb narrow = sat ? '1 : acc[OUT_W-1:0];

endmodule

// File: rtl/systolic_result_drain.sv
// Drains a captured 3x3 accumulator snapshot as a ready/valid stream of
// saturated elements, row-major, one element per handshake.
module systolic_result_drain
   import systolic_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 done,
   input  logic [9*ACC_W-1:0]   c_flat,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [OUT_W-1:0]     out_data,
   output logic [1:0]           out_row,
   output logic [1:0]           out_col,
   output logic                 out_last,
   output logic                 out_sat,
   output logic                 busy,
   output logic                 overrun,
   output logic                 matrix_out
);

   drain_state_t     state, state_nxt;
   logic [3:0]       index, index_nxt;
   logic [ACC_W-1:0] snap [N_ELEM];

   logic             idx_ok;
   logic             hs;
   logic             final_hs;
   logic             capture;
   logic             drop;
   logic [3:0]       rd_idx;
   logic [ACC_W-1:0] rd_val;
   logic [OUT_W-1:0] sat_data;
   logic             sat_flag;

   // Handshake and capture qualifiers shared by state, index and pulse logic
   always_comb begin
      idx_ok   = (index <= LAST_IDX);
      hs       = out_valid & out_ready;
      final_hs = hs & (index == LAST_IDX);
      capture  = done & ((state == ST_IDLE) | final_hs);
      drop     = done & (state == ST_DRAIN) & ~final_hs;
      rd_idx   = idx_ok ? index : '0;
      rd_val   = snap[rd_idx];
   end

   sat_narrow #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_sat (
      .acc    (rd_val),
      .narrow (sat_data),
      .sat    (sat_flag)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state and next-index logic; a done on the final handshake restarts the drain
   always_comb begin
      state_nxt = state;
      index_nxt = index;
      case (state)
         ST_IDLE: begin
            index_nxt = '0;
            if (done) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!idx_ok) begin
               state_nxt = ST_IDLE;
               index_nxt = '0;
            end else if (final_hs) begin
               index_nxt = '0;
               if (!done) state_nxt = ST_IDLE;
            end else if (hs) begin
               index_nxt = index + 4'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            index_nxt = '0;
         end
      endcase
   end

   // Element index and single-cycle status pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index      <= '0;
         overrun    <= 1'b0;
         matrix_out <= 1'b0;
      end else begin
         index      <= index_nxt;
         overrun    <= drop;
         matrix_out <= final_hs;
      end
   end

   // Snapshot bank: decoupled from c_flat once captured, so the array can be refed
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int unsigned i = 0; i < N_ELEM; i++) begin
            snap[i] <= c_flat[i*ACC_W +: ACC_W];
         end
      end
   end

   // Output decode: beat fields are forced to zero whenever no beat is presented
   always_comb begin
      busy      = (state == ST_DRAIN);
      out_valid = (state == ST_DRAIN) && idx_ok;
      out_data  = '0;
      out_row   = 2'd0;
      out_col   = 2'd0;
      out_last  = 1'b0;
      out_sat   = 1'b0;
      if (out_valid) begin
         out_data = sat_data;
         out_row  = idx_row(index);
         out_col  = idx_col(index);
         out_last = (index == LAST_IDX);
         out_sat  = sat_flag;
      end
   end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain.
module tb_systolic_result_drain;

   localparam int          ACC_W   = 20;
   localparam int          OUT_W   = 16;
   localparam int unsigned OUT_MAX = (1 << OUT_W) - 1;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               done;
   logic [9*ACC_W-1:0] c_flat;
   logic               out_ready;
   logic               out_valid;
   logic [OUT_W-1:0]   out_data;
   logic [1:0]         out_row;
   logic [1:0]         out_col;
   logic               out_last;
   logic               out_sat;
   logic               busy;
   logic               overrun;
   logic               matrix_out;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic [1:0]       row;
      logic [1:0]       col;
      logic             last;
      logic             sat;
   } beat_t;

   typedef struct packed {
      logic  v;
      logic  r;
      logic  busy;
      logic  mo;
      logic  ov;
      beat_t b;
   } cyc_t;

   beat_t exp_q[$];
   cyc_t  tr[$];
   int    checks = 0;
   int    errors = 0;

   systolic_result_drain #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .done       (done),
      .c_flat     (c_flat),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_last   (out_last),
      .out_sat    (out_sat),
      .busy       (busy),
      .overrun    (overrun),
      .matrix_out (matrix_out)
   );

   always #5 clk = ~clk;

   function automatic beat_t model_beat(input int unsigned idx, input int unsigned val);
      beat_t e;
      e.d    = OUT_W'((val > OUT_MAX) ? OUT_MAX : val);
      e.row  = 2'(idx / 3);
      e.col  = 2'(idx % 3);
      e.last = (idx == 8);
      e.sat  = (val > OUT_MAX);
      return e;
   endfunction

   task automatic load_c(input int unsigned v[9]);
      for (int i = 0; i < 9; i++) c_flat[i*ACC_W +: ACC_W] = ACC_W'(v[i]);
   endtask

   task automatic push_exp(input int unsigned v[9]);
      for (int i = 0; i < 9; i++) exp_q.push_back(model_beat(i, v[i]));
   endtask

   // Records this cycle's outputs with the inputs driven into the coming edge
   task automatic cycle(input logic dn, input logic rdy);
      cyc_t c;
      c.v    = out_valid;
      c.r    = rdy;
      c.busy = busy;
      c.mo   = matrix_out;
      c.ov   = overrun;
      c.b    = beat_t'({out_data, out_row, out_col, out_last, out_sat});
      tr.push_back(c);
      done      = dn;
      out_ready = rdy;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; done = 1'b0; out_ready = 1'b0; c_flat = '0;
      #1;
      checks++;
      if ({out_valid, out_data, out_row, out_col, out_last, out_sat, busy, overrun, matrix_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h required 0",
                  {out_valid, out_data, out_row, out_col, out_last, out_sat, busy, overrun, matrix_out});
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      tr.delete();
      repeat (3) cycle(1'b0, 1'b1);
      checks++;
      if (tr[2].v !== 1'b0 || tr[2].busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle valid=%b busy=%b required 0 0", tr[2].v, tr[2].busy);
      end
   endtask

   task automatic test_basic;
      int unsigned v[9];
      beat_t e;
      int hs = 0, mo = 0, ov = 0;
      tr.delete(); exp_q.delete();
      for (int i = 0; i < 9; i++) v[i] = i + 1;
      load_c(v); push_exp(v);
      cycle(1'b1, 1'b1);
      repeat (12) cycle(1'b0, 1'b1);
      foreach (tr[k]) begin
         if (tr[k].mo) mo++;
         if (tr[k].ov) ov++;
         if (tr[k].v && tr[k].r) begin
            if (k >= 1 && k <= 9) hs++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL basic_beat cycle %0d got extra beat %h required none", k, tr[k].b);
            end else begin
               e = exp_q.pop_front();
               if (tr[k].b !== e) begin
                  errors++; $display("FAIL basic_beat cycle %0d got %h required %h", k, tr[k].b, e);
               end
            end
         end
      end
      checks++;
      if (tr[1].v !== 1'b1) begin errors++; $display("FAIL basic_latency valid=%b required 1", tr[1].v); end
      checks++;
      if (hs != 9) begin errors++; $display("FAIL basic_consecutive got %0d handshakes in cycles 1..9 required 9", hs); end
      checks++;
      if (mo != 1 || tr[10].mo !== 1'b1) begin
         errors++; $display("FAIL basic_matrix_out count %0d at10=%b required 1 1", mo, tr[10].mo);
      end
      checks++;
      if (tr[5].busy !== 1'b1 || tr[11].busy !== 1'b0 || tr[10].v !== 1'b0) begin
         errors++; $display("FAIL basic_busy mid=%b end=%b valid10=%b required 1 0 0", tr[5].busy, tr[11].busy, tr[10].v);
      end
      checks++;
      if (ov != 0 || exp_q.size() != 0) begin
         errors++; $display("FAIL basic_leftover overrun %0d pending %0d required 0 0", ov, exp_q.size());
      end
   endtask

   task automatic test_stall;
      int unsigned v[9];
      beat_t e;
      int hs = 0, mo = 0;
      tr.delete(); exp_q.delete();
      for (int i = 0; i < 9; i++) v[i] = i + 1;
      load_c(v); push_exp(v);
      cycle(1'b1, 1'b1);
      for (int j = 1; j < 30; j++) cycle(1'b0, ((j - 1) % 3) == 0);
      foreach (tr[k]) begin
         if (tr[k].mo) mo++;
         if (tr[k].v && tr[k].r) begin
            hs++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stall_beat cycle %0d got extra beat %h required none", k, tr[k].b);
            end else begin
               e = exp_q.pop_front();
               if (tr[k].b !== e) begin
                  errors++; $display("FAIL stall_beat cycle %0d got %h required %h", k, tr[k].b, e);
               end
            end
         end else if (tr[k].v && k + 1 < tr.size()) begin
            checks++;
            if (tr[k+1].v !== 1'b1 || tr[k+1].b !== tr[k].b) begin
               errors++; $display("FAIL stall_hold cycle %0d got v=%b %h required v=1 %h", k + 1, tr[k+1].v, tr[k+1].b, tr[k].b);
            end
         end
      end
      checks++;
      if (hs != 9 || mo != 1) begin
         errors++; $display("FAIL stall_count handshakes %0d matrix_out %0d required 9 1", hs, mo);
      end
   endtask

   task automatic test_sat;
      int unsigned v[9];
      beat_t e;
      int sat_seen = 0;
      tr.delete(); exp_q.delete();
      for (int i = 0; i < 9; i++) v[i] = 5;
      v[4] = 70000;
      load_c(v); push_exp(v);
      cycle(1'b1, 1'b1);
      repeat (11) cycle(1'b0, 1'b1);
      for (int i = 0; i < 9; i++) v[i] = 0;
      v[0] = 65535; v[1] = 65536; v[2] = 1048575; v[3] = 1;
      load_c(v); push_exp(v);
      cycle(1'b1, 1'b1);
      repeat (11) cycle(1'b0, 1'b1);
      foreach (tr[k]) begin
         if (tr[k].v && tr[k].r) begin
            if (tr[k].b.sat) sat_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL sat_beat cycle %0d got extra beat %h required none", k, tr[k].b);
            end else begin
               e = exp_q.pop_front();
               if (tr[k].b !== e) begin
                  errors++; $display("FAIL sat_beat cycle %0d got %h required %h", k, tr[k].b, e);
               end
            end
         end
      end
      checks++;
      if (sat_seen != 3 || exp_q.size() != 0) begin
         errors++; $display("FAIL sat_count saturated %0d pending %0d required 3 0", sat_seen, exp_q.size());
      end
   endtask

   task automatic test_overrun;
      int unsigned v[9];
      int unsigned v7[9];
      beat_t e;
      int mo = 0, ov = 0;
      tr.delete(); exp_q.delete();
      for (int i = 0; i < 9; i++) begin v[i] = i + 1; v7[i] = 7; end
      load_c(v); push_exp(v);
      cycle(1'b1, 1'b1);
      repeat (2) cycle(1'b0, 1'b1);
      load_c(v7);
      cycle(1'b1, 1'b1);
      c_flat = '0;
      repeat (9) cycle(1'b0, 1'b1);
      foreach (tr[k]) begin
         if (tr[k].mo) mo++;
         if (tr[k].ov) ov++;
         if (tr[k].v && tr[k].r) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL overrun_beat cycle %0d got extra beat %h required none", k, tr[k].b);
            end else begin
               e = exp_q.pop_front();
               if (tr[k].b !== e) begin
                  errors++; $display("FAIL overrun_beat cycle %0d got %h required %h", k, tr[k].b, e);
               end
            end
         end
      end
      checks++;
      if (ov != 1 || tr[4].ov !== 1'b1) begin
         errors++; $display("FAIL overrun_pulse count %0d at4=%b required 1 1", ov, tr[4].ov);
      end
      checks++;
      if (mo != 1 || exp_q.size() != 0) begin
         errors++; $display("FAIL overrun_end matrix_out %0d pending %0d required 1 0", mo, exp_q.size());
      end
   endtask

   task automatic test_back_to_back;
      int unsigned v[9];
      int unsigned v2[9];
      beat_t e;
      int mo = 0, ov = 0, vcnt = 0;
      tr.delete(); exp_q.delete();
      for (int i = 0; i < 9; i++) begin v[i] = i + 1; v2[i] = 2; end
      load_c(v); push_exp(v);
      cycle(1'b1, 1'b1);
      repeat (8) cycle(1'b0, 1'b1);
      load_c(v2); push_exp(v2);
      cycle(1'b1, 1'b1);
      repeat (12) cycle(1'b0, 1'b1);
      foreach (tr[k]) begin
         if (tr[k].mo) mo++;
         if (tr[k].ov) ov++;
         if (k >= 1 && k <= 18 && tr[k].v) vcnt++;
         if (tr[k].v && tr[k].r) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_beat cycle %0d got extra beat %h required none", k, tr[k].b);
            end else begin
               e = exp_q.pop_front();
               if (tr[k].b !== e) begin
                  errors++; $display("FAIL b2b_beat cycle %0d got %h required %h", k, tr[k].b, e);
               end
            end
         end
      end
      checks++;
      if (vcnt != 18 || tr[19].v !== 1'b0) begin
         errors++; $display("FAIL b2b_no_gap valid cycles %0d v19=%b required 18 0", vcnt, tr[19].v);
      end
      checks++;
      if (mo != 2 || tr[10].mo !== 1'b1 || tr[19].mo !== 1'b1) begin
         errors++; $display("FAIL b2b_matrix_out count %0d at10=%b at19=%b required 2 1 1", mo, tr[10].mo, tr[19].mo);
      end
      checks++;
      if (ov != 0 || exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_overrun count %0d pending %0d required 0 0", ov, exp_q.size());
      end
   endtask

   task automatic test_reset_mid;
      int unsigned v[9];
      beat_t e;
      int mo = 0;
      tr.delete(); exp_q.delete();
      for (int i = 0; i < 9; i++) v[i] = i + 1;
      load_c(v); push_exp(v);
      cycle(1'b1, 1'b1);
      repeat (3) cycle(1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd4) begin
         errors++; $display("FAIL rstmid_beat4 valid=%b data=%0d required 1 4", out_valid, out_data);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_data, out_row, out_col, out_last, out_sat, busy, overrun, matrix_out} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs got %h required 0",
                  {out_valid, out_data, out_row, out_col, out_last, out_sat, busy, overrun, matrix_out});
      end
      foreach (tr[k]) begin
         if (tr[k].v && tr[k].r) begin
            checks++;
            e = exp_q.pop_front();
            if (tr[k].b !== e) begin
               errors++; $display("FAIL rstmid_pre cycle %0d got %h required %h", k, tr[k].b, e);
            end
         end
      end
      exp_q.delete(); tr.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) cycle(1'b0, 1'b1);
      push_exp(v);
      cycle(1'b1, 1'b1);
      repeat (11) cycle(1'b0, 1'b1);
      foreach (tr[k]) begin
         if (tr[k].mo) mo++;
         if (tr[k].v && tr[k].r) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rstmid_beat cycle %0d got extra beat %h required none", k, tr[k].b);
            end else begin
               e = exp_q.pop_front();
               if (tr[k].b !== e) begin
                  errors++; $display("FAIL rstmid_beat cycle %0d got %h required %h", k, tr[k].b, e);
               end
            end
         end
      end
      checks++;
      if (mo != 1 || tr[12].mo !== 1'b1 || tr[3].v !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rstmid_after matrix_out %0d at12=%b v3=%b pending %0d required 1 1 1 0",
                  mo, tr[12].mo, tr[3].v, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_sat();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
